sram_bus_ctrl: RTL and testbench
================================

# sram_bus_ctrl

Synchronous front-end that turns a valid/ready request stream into the strobe sequence of the banked SRAM bus (addr, bidirectional data, chip_select, write_enable, output_enable). It sits directly upstream of the 4-bank, 16-bit RAM array. It owns the tri-state data bus and inserts a turnaround cycle after every read. It returns read data on a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 12, word address width; the top 2 bits select the bank inside the RAM array.
- DATA_WIDTH, 16, data word width.
- READ_LATENCY, 1, cycles the read strobes are held before data is sampled; legal range 1..4.
- clk  in  1  single clock; everything is updated on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle pulse carrying read data.
- resp_rdata  out  DATA_WIDTH  read data; valid only while resp_valid=1.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_data  inout  DATA_WIDTH  to RAM data.
- ram_cs  out  1  to RAM chip_select.
- ram_we  out  1  to RAM write_enable.
- ram_oe  out  1  to RAM output_enable.

## Operation
- States: IDLE, WRITE, READ, TURN.
- IDLE
  - req_ready=1 and all strobes are 0.
  - On req_valid&&req_ready, req_addr, req_wdata and req_write are latched.
  - Next state is WRITE if req_write=1, else READ.
- WRITE (exactly 1 cycle)
  - ram_cs=1, ram_we=1, ram_oe=0.
  - ram_data is driven with the latched wdata.
  - Next state: IDLE. Writes produce no resp_valid.
- READ (READ_LATENCY cycles, using an internal down-counter)
  - ram_cs=1, ram_we=0, ram_oe=1. ram_data is high-Z.
  - On the last READ cycle ram_data is registered into resp_rdata.
  - Next state: TURN.
- TURN (exactly 1 cycle)
  - All strobes are 0 and ram_data is high-Z.
  - resp_valid=1.
  - Next state: IDLE.
- ram_addr holds the latched address from the accept edge until the next accept. It does not change while any strobe is asserted.
- ram_data is driven only in WRITE and is 'z in every other state, including reset. The controller therefore never drives the bus in the cycle after ram_oe falls.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored, and the requester must hold it.
- No address checking is done: every ADDR_WIDTH value is legal, 0x000 through 0xFFF maps across all four banks.
- Reset
  - rst_n=0 at an edge forces IDLE and clears the READ counter.
  - An in-flight access is dropped: no resp_valid, no write completes after the reset edge.
  - Reset values: req_ready=1, resp_valid=0, resp_rdata=0, ram_addr=0, ram_cs=0, ram_we=0, ram_oe=0, ram_data='z.

## Timing
- All outputs are registered except ram_data enable, which is decoded from state.
- Write: accepted at edge 0, WRITE during cycle 1, req_ready=1 again in cycle 2. Throughput is 1 write per 2 cycles.
- Read: accepted at edge 0, READ during cycles 1..L, resp_valid during cycle L+1, req_ready=1 in cycle L+2. With L=1 this is 1 read per 3 cycles.
- Read followed by write: the write's data drive starts no earlier than 2 cycles after ram_oe deasserts.

## Configuration
- Macro SRAM_BUS_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_reads and stat_writes, 16 bits each, saturating at 0xFFFF.
  - stat_writes increments on entry to WRITE; stat_reads increments on the resp_valid cycle.
  - Both are cleared by reset.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then an idle check: hold rst_n=0 for 2 cycles, then release.
  - Required: req_ready=1, all strobes 0, ram_data='z, resp_valid=0.
- Write then read with L=1:
  - Write addr 0x123, data 0xBEEF: ram_cs=ram_we=1 for exactly 1 cycle with ram_data=0xBEEF.
  - Read 0x123: resp_valid pulses 2 cycles after accept, resp_rdata=0xBEEF.
- Bank boundaries:
  - Write 0x000=0x1111, 0x3FF=0x2222, 0x400=0x3333, 0xFFF=0x4444.
  - Read back in reverse order: each returns its own value, with no aliasing.
- Read followed by write:
  - Read 0xC00, then write 0xC00=0xA5A5 presented back-to-back.
  - Required: the write is not accepted before the TURN cycle completes; ram_data is 'z on the cycle after ram_oe falls; a re-read returns 0xA5A5.
- Reset mid-read with READ_LATENCY=3:
  - Assert rst_n=0 in the 2nd READ cycle.
  - Required: no resp_valid, strobes 0 on the next cycle, req_ready=1.
- With SRAM_BUS_CTRL_STATS_EN defined:
  - Issue 5 writes and 3 reads: stat_writes=5, stat_reads=3.
  - Force stat_reads to 0xFFFF, issue a read: it stays at 0xFFFF.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// Valid/ready front-end for the 4-bank 16-bit SRAM bus: registered strobes, tri-state data, read turnaround.
// Optional macro SRAM_BUS_CTRL_STATS_EN adds saturating read/write counters (stat_reads, stat_writes).
module sram_bus_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1   // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
`ifdef SRAM_BUS_CTRL_STATS_EN
    ,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        TURN
    } state_t;

    // Two bits cover the full 1..4 latency range; the counter counts down to zero.
    localparam logic [1:0] RD_CNT_INIT = 2'(READ_LATENCY - 1);

    state_t                state;
    logic [1:0]            rd_cnt;
    logic [DATA_WIDTH-1:0] wdata_q;

    // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            ram_addr   <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_oe     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ram_addr  <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        ram_cs    <= 1'b1;
                        if (req_write) begin
                            state  <= WRITE;
                            ram_we <= 1'b1;
                        end else begin
                            state  <= READ;
                            ram_oe <= 1'b1;
                            rd_cnt <= RD_CNT_INIT;
                        end
                    end
                end
                WRITE: begin
                    state     <= IDLE;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    req_ready <= 1'b1;
                end
                READ: begin
                    // Sample the bus while the strobes are still held for the final cycle.
                    if (rd_cnt == 2'd0) begin
                        resp_rdata <= ram_data;
                        resp_valid <= 1'b1;
                        ram_cs     <= 1'b0;
                        ram_oe     <= 1'b0;
                        state      <= TURN;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                TURN: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus drive is decoded straight from state so it can never overlap a read or its turnaround.
    assign ram_data = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef SRAM_BUS_CTRL_STATS_EN
    logic [15:0] stat_reads_q;
    logic [15:0] stat_writes_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            if (state == IDLE && req_valid && req_ready && req_write && stat_writes_q != 16'hFFFF)
                stat_writes_q <= stat_writes_q + 16'd1;
            if (resp_valid && stat_reads_q != 16'hFFFF)
                stat_reads_q <= stat_reads_q + 16'd1;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: one instance with READ_LATENCY=1, one with READ_LATENCY=3,
// each attached to a behavioural RAM model. Stats checks are enabled by SRAM_BUS_CTRL_STATS_EN.
`timescale 1ns/1ps
module tb_sram_bus_ctrl;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: READ_LATENCY = 1
    logic          rst_n_a, req_valid_a, req_write_a, req_ready_a, resp_valid_a;
    logic [AW-1:0] req_addr_a, ram_addr_a;
    logic [DW-1:0] req_wdata_a, resp_rdata_a;
    wire  [DW-1:0] ram_data_a;
    logic          ram_cs_a, ram_we_a, ram_oe_a;

    // Instance B: READ_LATENCY = 3
    logic          rst_n_b, req_valid_b, req_write_b, req_ready_b, resp_valid_b;
    logic [AW-1:0] req_addr_b, ram_addr_b;
    logic [DW-1:0] req_wdata_b, resp_rdata_b;
    wire  [DW-1:0] ram_data_b;
    logic          ram_cs_b, ram_we_b, ram_oe_b;

`ifdef SRAM_BUS_CTRL_STATS_EN
    logic [15:0] stat_reads_a, stat_writes_a, stat_reads_b, stat_writes_b;
`endif

    sram_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a),
        .ram_cs(ram_cs_a), .ram_we(ram_we_a), .ram_oe(ram_oe_a)
`ifdef SRAM_BUS_CTRL_STATS_EN
        , .stat_reads(stat_reads_a), .stat_writes(stat_writes_a)
`endif
    );

    sram_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b),
        .ram_cs(ram_cs_b), .ram_we(ram_we_b), .ram_oe(ram_oe_b)
`ifdef SRAM_BUS_CTRL_STATS_EN
        , .stat_reads(stat_reads_b), .stat_writes(stat_writes_b)
`endif
    );

    // Behavioural RAMs: combinational read while selected with output enable, write at the edge.
    logic [DW-1:0] mem_a [4096];
    logic [DW-1:0] mem_b [4096];

    assign ram_data_a = (ram_cs_a && ram_oe_a && !ram_we_a) ? mem_a[ram_addr_a] : {DW{1'bz}};
    assign ram_data_b = (ram_cs_b && ram_oe_b && !ram_we_b) ? mem_b[ram_addr_b] : {DW{1'bz}};

    always @(posedge clk) if (ram_cs_a && ram_we_a) mem_a[ram_addr_a] <= ram_data_a;
    always @(posedge clk) if (ram_cs_b && ram_we_b) mem_b[ram_addr_b] <= ram_data_b;

    logic [DW-1:0] sb_a[$];
    logic [DW-1:0] sb_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Undriven bus reads as z in 4-state simulators and 0 in 2-state ones; the controller's
    // latched wdata is always nonzero in this bench, so a stray drive is still visible.
    function automatic logic released(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
    endfunction

    always @(negedge clk) begin
        if (resp_valid_a) begin
            if (sb_a.size() == 0) check("a_unexpected_resp", sb_a.size(), 1);
            else check("a_rdata", resp_rdata_a, sb_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (resp_valid_b) begin
            if (sb_b.size() == 0) check("b_unexpected_resp", sb_b.size(), 1);
            else check("b_rdata", resp_rdata_b, sb_b.pop_front());
        end
    end

    // Present a request, wait until it is accepted, return at the negedge after the accept edge
    // with req_valid still high so the caller can chain another request back-to-back.
    task automatic issue_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_rd);
        int n = 0;
        req_valid_a = 1'b1; req_write_a = w; req_addr_a = a; req_wdata_a = d;
        while (!req_ready_a && n < 20) begin @(negedge clk); n++; end
        check("a_accept_wait", n < 20, 1'b1);
        if (!w) sb_a.push_back(exp_rd);
        @(negedge clk);
    endtask

    task automatic idle_a();
        int n = 0;
        req_valid_a = 1'b0;
        while ((sb_a.size() != 0 || !req_ready_a) && n < 20) begin @(negedge clk); n++; end
        check("a_drain", sb_a.size(), 0);
    endtask

    task automatic issue_b(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid_b = 1'b1; req_write_b = w; req_addr_b = a; req_wdata_b = d;
        while (!req_ready_b && n < 20) begin @(negedge clk); n++; end
        check("b_accept_wait", n < 20, 1'b1);
        @(negedge clk);
        req_valid_b = 1'b0;
    endtask

    task automatic idle_b();
        int n = 0;
        while ((sb_b.size() != 0 || !req_ready_b) && n < 20) begin @(negedge clk); n++; end
        check("b_drain", sb_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_ready",  req_ready_a,  1'b1);
        check("rst_cs",     ram_cs_a,     1'b0);
        check("rst_we",     ram_we_a,     1'b0);
        check("rst_oe",     ram_oe_a,     1'b0);
        check("rst_resp",   resp_valid_a, 1'b0);
        check("rst_rdata",  resp_rdata_a, 16'h0000);
        check("rst_addr",   ram_addr_a,   12'h000);
        check("rst_bus_z",  released(ram_data_a), 1'b1);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
        check("idle_ready", req_ready_a, 1'b1);
        check("idle_cs",    ram_cs_a,    1'b0);
        check("idle_resp",  resp_valid_a, 1'b0);

        // Single write 0x123 = 0xBEEF
        issue_a(1'b1, 12'h123, 16'hBEEF, 16'h0);
        req_valid_a = 1'b0;
        check("wr_cs",    ram_cs_a,   1'b1);
        check("wr_we",    ram_we_a,   1'b1);
        check("wr_oe",    ram_oe_a,   1'b0);
        check("wr_data",  ram_data_a, 16'hBEEF);
        check("wr_addr",  ram_addr_a, 12'h123);
        check("wr_ready", req_ready_a, 1'b0);
        @(negedge clk);
        check("wr_end_cs",   ram_cs_a,  1'b0);
        check("wr_end_we",   ram_we_a,  1'b0);
        check("wr_end_rdy",  req_ready_a, 1'b1);
        check("wr_end_addr", ram_addr_a, 12'h123);
        check("wr_end_z",    released(ram_data_a), 1'b1);

        // Read 0x123 with L=1: READ in cycle 1, resp_valid in cycle 2, ready in cycle 3
        issue_a(1'b0, 12'h123, 16'h0BAD, 16'hBEEF);
        req_valid_a = 1'b0;
        check("rd_cs",   ram_cs_a, 1'b1);
        check("rd_oe",   ram_oe_a, 1'b1);
        check("rd_we",   ram_we_a, 1'b0);
        check("rd_resp_early", resp_valid_a, 1'b0);
        @(negedge clk);
        check("rd_resp",    resp_valid_a, 1'b1);
        check("turn_cs",    ram_cs_a,  1'b0);
        check("turn_oe",    ram_oe_a,  1'b0);
        check("turn_ready", req_ready_a, 1'b0);
        check("turn_z",     released(ram_data_a), 1'b1);
        @(negedge clk);
        check("rd_resp_pulse", resp_valid_a, 1'b0);
        check("rd_ready_back", req_ready_a, 1'b1);

        // Bank boundaries, read back in reverse order
        issue_a(1'b1, 12'h000, 16'h1111, 16'h0);
        issue_a(1'b1, 12'h3FF, 16'h2222, 16'h0);
        issue_a(1'b1, 12'h400, 16'h3333, 16'h0);
        issue_a(1'b1, 12'hFFF, 16'h4444, 16'h0);
        issue_a(1'b0, 12'hFFF, 16'h0BAD, 16'h4444);
        issue_a(1'b0, 12'h400, 16'h0BAD, 16'h3333);
        issue_a(1'b0, 12'h3FF, 16'h0BAD, 16'h2222);
        issue_a(1'b0, 12'h000, 16'h0BAD, 16'h1111);
        idle_a();

        // Read 0xC00 followed back-to-back by a write to 0xC00
        issue_a(1'b1, 12'hC00, 16'h5A5A, 16'h0);
        issue_a(1'b0, 12'hC00, 16'h7777, 16'h5A5A);
        req_write_a = 1'b1; req_addr_a = 12'hC00; req_wdata_a = 16'hA5A5;
        check("rw_read_oe",    ram_oe_a, 1'b1);
        check("rw_read_ready", req_ready_a, 1'b0);
        @(negedge clk);
        check("rw_turn_oe",    ram_oe_a, 1'b0);
        check("rw_turn_we",    ram_we_a, 1'b0);
        check("rw_turn_ready", req_ready_a, 1'b0);
        check("rw_turn_z",     released(ram_data_a), 1'b1);
        @(negedge clk);
        check("rw_idle_cs",    ram_cs_a, 1'b0);
        check("rw_idle_ready", req_ready_a, 1'b1);
        check("rw_idle_z",     released(ram_data_a), 1'b1);
        @(negedge clk);
        req_valid_a = 1'b0;
        check("rw_wr_we",   ram_we_a,   1'b1);
        check("rw_wr_data", ram_data_a, 16'hA5A5);
        issue_a(1'b0, 12'hC00, 16'h0BAD, 16'hA5A5);
        idle_a();

        // Instance B (L=3): full read timing
        issue_b(1'b1, 12'h055, 16'h1234);
        idle_b();
        sb_b.push_back(16'h1234);
        issue_b(1'b0, 12'h055, 16'h0BAD);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("b_read%0d_oe", i), ram_oe_b, 1'b1);
            check($sformatf("b_read%0d_resp", i), resp_valid_b, 1'b0);
            @(negedge clk);
        end
        check("b_resp", resp_valid_b, 1'b1);
        check("b_turn_oe", ram_oe_b, 1'b0);
        @(negedge clk);
        check("b_ready_back", req_ready_b, 1'b1);

        // Instance B: reset during the 2nd READ cycle drops the access
        issue_b(1'b0, 12'h055, 16'h0BAD);
        check("b_abort_rd1_oe", ram_oe_b, 1'b1);
        @(negedge clk);
        check("b_abort_rd2_oe", ram_oe_b, 1'b1);
        rst_n_b = 1'b0;
        @(negedge clk);
        check("b_abort_cs",    ram_cs_b, 1'b0);
        check("b_abort_oe",    ram_oe_b, 1'b0);
        check("b_abort_we",    ram_we_b, 1'b0);
        check("b_abort_ready", req_ready_b, 1'b1);
        check("b_abort_resp",  resp_valid_b, 1'b0);
        check("b_abort_z",     released(ram_data_b), 1'b1);
        rst_n_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_abort_quiet", resp_valid_b, 1'b0);
        end
        sb_b.push_back(16'h1234);
        issue_b(1'b0, 12'h055, 16'h0BAD);
        idle_b();

`ifdef SRAM_BUS_CTRL_STATS_EN
        // A: 7 writes (0x123, four bank, two 0xC00) and 7 completed reads so far
        check("stat_writes_a", stat_writes_a, 16'd7);
        check("stat_reads_a",  stat_reads_a,  16'd7);
        // B: counters cleared by the mid-read reset, then one completed read
        check("stat_writes_b", stat_writes_b, 16'd0);
        check("stat_reads_b",  stat_reads_b,  16'd1);
        force dut_a.stat_reads_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.stat_reads_q;
        issue_a(1'b0, 12'h123, 16'h0BAD, 16'hBEEF);
        idle_a();
        @(negedge clk);
        check("stat_reads_sat", stat_reads_a, 16'hFFFF);
`endif

        check("sb_a_empty", sb_a.size(), 0);
        check("sb_b_empty", sb_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
